// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
// Consumed by instr_queue and instr_queue_mem.
package instr_queue_pkg;

  localparam int          DEPTH_DEF = 4;
  localparam int          INSTR_W   = 32;
  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  // Pointer width for a power-of-two depth (2..16); never below 1 bit.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for instr_queue: DEPTH x {instr, pc} register array.
// One synchronous write port and one asynchronous read port; contents are never reset.
module instr_queue_mem
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = addr_width(DEPTH_DEF)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_queue.sv
// Instruction prefetch queue: circular FIFO of {instr, pc} between fetch and decode.
// Define INSTR_QUEUE_BYPASS_EN to forward the incoming word to the output when the queue is empty.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc4,
  output logic [AW:0]        count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          stored_valid, byp, push, pop;
  entry_t        rd_entry, head;

  assign stored_valid = (count_q != '0);
  assign in_ready     = (count_q != FULL);

`ifdef INSTR_QUEUE_BYPASS_EN
  assign byp = !stored_valid && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word taken by decode in the same cycle is never stored.
  assign out_valid = stored_valid | byp;
  assign push      = in_valid & in_ready & ~(byp & out_ready);
  assign pop       = stored_valid & out_ready;

  assign head      = byp ? entry_t'{instr: in_instr, pc: in_pc} : rd_entry;
  assign out_instr = out_valid ? head.instr : NOP;
  assign out_pc    = out_valid ? head.pc : '0;
  assign out_pc4   = out_pc + 32'd4;
  assign count     = count_q;

  instr_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (entry_t'{instr: in_instr, pc: in_pc}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=4).
// Covers INSTR_QUEUE_BYPASS_EN when the macro is defined for the build.
module tb_instr_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_pc4;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic push_word(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    checks++; if (out_pc4 !== 32'h4) begin errors++; $display("FAIL reset_out_pc4 got %h want 4", out_pc4); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_word(32'h3000 + 32'(4 * i));
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    push_word(32'h3010);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fifth_push_count got %0d want 4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * i) || out_instr !== {16'hC0DE, 16'h3000 + 16'(4 * i)} || out_pc4 !== 32'h3004 + 32'(4 * i))
        begin errors++; $display("FAIL drain_%0d got v=%b pc=%h instr=%h pc4=%h want pc=%h", i, out_valid, out_pc, out_instr, out_pc4, 32'h3000 + 32'(4 * i)); end
      tick();
    end
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got count=%0d v=%b want 0/0", count, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_word(32'h4000);
    push_word(32'h4004);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_pc    = 32'h4008 + 32'(4 * k);
      in_instr = instr_of(in_pc);
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4000 + 32'(4 * k) || out_instr !== {16'hC0DE, 16'h4000 + 16'(4 * k)} || count !== 3'd2)
        begin errors++; $display("FAIL stream_%0d got v=%b pc=%h instr=%h count=%0d want pc=%h count=2", k, out_valid, out_pc, out_instr, count, 32'h4000 + 32'(4 * k)); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (count !== 3'd2 || out_pc !== 32'h4050) begin errors++; $display("FAIL stream_tail got count=%0d pc=%h want 2/4050", count, out_pc); end
  endtask

  task automatic test_flush();
    do_reset();
    push_word(32'h5000);
    push_word(32'h5004);
    push_word(32'h5008);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h5FF0;
    in_instr = 32'hDEAD_BEEF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_state got count=%0d v=%b rdy=%b want 0/0/1", count, out_valid, in_ready); end
    push_word(32'h6000);
    checks++; if (count !== 3'd1 || out_pc !== 32'h6000 || out_instr !== 32'hC0DE_6000)
      begin errors++; $display("FAIL after_flush got count=%0d pc=%h instr=%h want 1/6000/c0de6000", count, out_pc, out_instr); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h7000 + 32'(4 * i));
    in_valid  = 1'b1;
    in_pc     = 32'h7010;
    in_instr  = instr_of(32'h7010);
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %b want 0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3 || out_pc !== 32'h7004) begin errors++; $display("FAIL full_pop got count=%0d pc=%h want 3/7004", count, out_pc); end
    tick();
    tick();
    checks++; if (out_pc !== 32'h700C || count !== 3'd1) begin errors++; $display("FAIL full_pop_last got pc=%h count=%0d want 700c/1", out_pc, count); end
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL full_pop_refused got v=%b count=%0d want 0/0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    push_word(32'h9000);
    push_word(32'h9004);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc4 !== 32'h4 || in_ready !== 1'b1)
      begin errors++; $display("FAIL async_reset got count=%0d v=%b instr=%h pc4=%h rdy=%b want 0/0/0/4/1", count, out_valid, out_instr, out_pc4, in_ready); end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    do_reset();
    in_valid  = 1'b1;
    in_pc     = 32'h8000;
    in_instr  = 32'h1234_5678;
    out_ready = 1'b1;
    #1;
`ifdef INSTR_QUEUE_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h1234_5678 || out_pc !== 32'h8000 || out_pc4 !== 32'h8004)
      begin errors++; $display("FAIL bypass_same_cycle got v=%b instr=%h pc=%h pc4=%h want 1/12345678/8000/8004", out_valid, out_instr, out_pc, out_pc4); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", count); end
`else
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin errors++; $display("FAIL no_bypass got v=%b instr=%h want 0/0", out_valid, out_instr); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (count !== 3'd1 || out_pc !== 32'h8000 || out_instr !== 32'h1234_5678)
      begin errors++; $display("FAIL latency_one got count=%0d pc=%h instr=%h want 1/8000/12345678", count, out_pc, out_instr); end
`endif
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_full_pop();
    test_async_reset();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
